sr_ff_bank: RTL

Parametrised bank of WIDTH independent SR flip-flops with a shared clock enable, synchronous parallel load, and a configurable policy for the S=R=1 case. Each bit flags conflicts per cycle and in a sticky register; a saturating counter records cycles with any conflict. It is the general-purpose replacement for single-bit SR storage in status and flag registers across the design.

---
 rtl/sr_bank_pkg.sv | 37 +++
 rtl/sr_cell.sv | 59 +++++
 rtl/sr_ff_bank.sv | 87 ++++++++
 3 files changed

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR flip-flop bank: conflict-policy codes and
// the single-bit next-state rule used by every storage cell.
package sr_bank_pkg;

  localparam int MODE_HOLD    = 0;
  localparam int MODE_RST_DOM = 1;
  localparam int MODE_SET_DOM = 2;
  localparam int MODE_TOGGLE  = 3;

  typedef enum logic [1:0] {
    REQ_HOLD = 2'b00,
    REQ_CLR  = 2'b01,
    REQ_SET  = 2'b10,
    REQ_BOTH = 2'b11
  } sr_req_e;

  function automatic logic sr_next(input int mode, input logic q, input logic s, input logic r);
    logic nxt;
    nxt = q;
    case (sr_req_e'({s, r}))
      REQ_HOLD: nxt = q;
      REQ_CLR:  nxt = 1'b0;
      REQ_SET:  nxt = 1'b1;
      REQ_BOTH: begin
        case (mode)
          MODE_RST_DOM: nxt = 1'b0;
          MODE_SET_DOM: nxt = 1'b1;
          MODE_TOGGLE:  nxt = ~q;
          default:      nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR storage bit with its one-cycle conflict flag and sticky conflict flag.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int   MODE      = MODE_HOLD,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic upd,
  input  logic d,
  input  logic s,
  input  logic r,
  input  logic clr_err,
  output logic hit,
  output logic q,
  output logic conflict,
  output logic conflict_sticky
);

  logic q_reg;
  logic q_next;
  logic conflict_reg;
  logic sticky_reg;
  logic sticky_next;

  // A conflict only exists when the S/R path is actually selected (ld wins).
  assign hit = upd & s & r;

  always_comb begin
    q_next = q_reg;
    if (ld) begin
      q_next = d;
    end else if (upd) begin
      q_next = sr_next(MODE, q_reg, s, r);
    end
  end

  // A fresh conflict beats a simultaneous clear.
  assign sticky_next = hit | (sticky_reg & ~clr_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg        <= RESET_BIT;
      conflict_reg <= 1'b0;
      sticky_reg   <= 1'b0;
    end else begin
      q_reg        <= q_next;
      conflict_reg <= hit;
      sticky_reg   <= sticky_next;
    end
  end

  assign q               = q_reg;
  assign conflict        = conflict_reg;
  assign conflict_sticky = sticky_reg;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH SR flip-flops with parallel load, selectable S=R=1 policy,
// per-bit conflict flags and a saturating count of conflicting cycles.
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] conflict,
  output logic [WIDTH-1:0] conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (CONFLICT_MODE < MODE_HOLD || CONFLICT_MODE > MODE_TOGGLE) begin : g_bad_mode
    $fatal(1, "sr_ff_bank: CONFLICT_MODE must be 0..3");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             upd;
  logic [WIDTH-1:0] hit;
  logic             any_hit;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Load takes precedence over S/R updates.
  assign upd = en & ~ld;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    sr_cell #(
      .MODE      (CONFLICT_MODE),
      .RESET_BIT (RESET_VAL[gi])
    ) u_cell (
      .clk             (clk),
      .rst             (rst),
      .ld              (ld),
      .upd             (upd),
      .d               (d[gi]),
      .s               (s[gi]),
      .r               (r[gi]),
      .clr_err         (clr_err),
      .hit             (hit[gi]),
      .q               (q[gi]),
      .conflict        (conflict[gi]),
      .conflict_sticky (conflict_sticky[gi])
    );
  end

  assign any_hit = |hit;

  always_comb begin
    cnt_next = cnt_reg;
    if (any_hit) begin
      if (clr_err) begin
        cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_reg != CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (clr_err) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign conflict_cnt = cnt_reg;
  assign q_bar        = ~q;

endmodule
